// File: rtl/pipe_ctrl.sv
// Stall/flush/redirect controller for the 5-stage core, including trap-entry sequencing.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter logic [31:0] RESET_ADDR  = 32'h0000_0000,
  parameter int          BUS_TIMEOUT = 255,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ifu_wait_i,
  input  logic             ld_use_i,
  input  logic             ex_busy_i,
  input  logic             lsu_wait_i,
  input  logic             jump_req_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             trap_req_i,
  input  logic [31:0]      trap_vec_i,
  output logic [4:0]       stall_o,
  output logic [4:0]       flush_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_addr_o,
  output logic             trap_ack_o,
  output logic             bus_timeout_o,
  output logic [CNT_W-1:0] stall_cyc_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  typedef enum logic [1:0] {RUN, DRAIN, TRAP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(BUS_TIMEOUT - 1);

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next;
  logic [31:0] vec, vec_next;

  logic [4:0]  stall, flush;
  logic        redirect, trap_ack, bus_timeout;
  logic [31:0] redirect_addr;
  logic        busy;

  assign busy = lsu_wait_i | ex_busy_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
      vec   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      vec   <= vec_next;
    end
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    vec_next      = vec;
    stall         = 5'b00000;
    flush         = 5'b00000;
    redirect      = 1'b0;
    redirect_addr = jump_addr_i;
    trap_ack      = 1'b0;
    bus_timeout   = 1'b0;
    case (state)
      RUN: begin
        // A pending trap suppresses jumps and front-end hazards but not the back-end stalls.
        if (lsu_wait_i) begin
          stall = 5'b11111;
        end else if (ex_busy_i) begin
          stall = 5'b00111;
          flush = 5'b01000;
        end else if (!trap_req_i) begin
          if (jump_req_i) begin
            flush    = 5'b00110;
            redirect = 1'b1;
          end else if (ld_use_i) begin
            stall = 5'b00011;
            flush = 5'b00100;
          end else if (ifu_wait_i) begin
            stall = 5'b00001;
            flush = 5'b00010;
          end
        end
        if (trap_req_i) begin
          state_next = DRAIN;
          vec_next   = trap_vec_i;
          cnt_next   = '0;
        end
      end
      DRAIN: begin
        stall    = lsu_wait_i ? 5'b11111 : (ex_busy_i ? 5'b00111 : 5'b00001);
        flush    = busy ? 5'b00000 : 5'b00010;
        cnt_next = cnt + 16'd1;
        if (!busy) begin
          state_next = TRAP;
        end else if (cnt == TMO_LAST) begin
          bus_timeout = 1'b1;
          state_next  = TRAP;
        end
      end
      TRAP: begin
        flush         = 5'b01110;
        redirect      = 1'b1;
        redirect_addr = vec;
        trap_ack      = 1'b1;
        cnt_next      = '0;
        state_next    = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // Outputs are forced to their idle values for as long as reset is held.
  assign stall_o         = rst_n ? stall       : 5'b00000;
  assign flush_o         = rst_n ? flush       : 5'b00000;
  assign redirect_o      = rst_n ? redirect    : 1'b0;
  assign redirect_addr_o = rst_n ? redirect_addr : RESET_ADDR;
  assign trap_ack_o      = rst_n ? trap_ack    : 1'b0;
  assign bus_timeout_o   = rst_n ? bus_timeout : 1'b0;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cyc, redirect_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cyc    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (stall_o[0]) stall_cyc <= stall_cyc + CNT_W'(1);
      if (redirect_o) redirect_cnt <= redirect_cnt + CNT_W'(1);
    end
  end

  assign stall_cyc_o    = stall_cyc;
  assign redirect_cnt_o = redirect_cnt;
`else
  assign stall_cyc_o    = '0;
  assign redirect_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a rule-level model predicts each cycle's outputs,
// a monitor compares them half a cycle after the inputs are applied.
module tb_pipe_ctrl;

  localparam logic [31:0] RST_ADDR = 32'hCAFE_0000;
  localparam int          TMO      = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_wait_i = 1'b0, ld_use_i = 1'b0, ex_busy_i = 1'b0, lsu_wait_i = 1'b0;
  logic        jump_req_i = 1'b0, trap_req_i = 1'b0;
  logic [31:0] jump_addr_i = '0, trap_vec_i = '0;
  logic [4:0]  stall_o, flush_o;
  logic        redirect_o, trap_ack_o, bus_timeout_o;
  logic [31:0] redirect_addr_o, stall_cyc_o, redirect_cnt_o;

  pipe_ctrl #(.RESET_ADDR(RST_ADDR), .BUS_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_wait_i(ifu_wait_i), .ld_use_i(ld_use_i), .ex_busy_i(ex_busy_i),
    .lsu_wait_i(lsu_wait_i), .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i),
    .trap_req_i(trap_req_i), .trap_vec_i(trap_vec_i),
    .stall_o(stall_o), .flush_o(flush_o), .redirect_o(redirect_o),
    .redirect_addr_o(redirect_addr_o), .trap_ack_o(trap_ack_o),
    .bus_timeout_o(bus_timeout_o), .stall_cyc_o(stall_cyc_o),
    .redirect_cnt_o(redirect_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        redir;
    logic [31:0] addr;
    logic        ack;
    logic        tmo;
    logic [31:0] scyc;
    logic [31:0] rcnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: trap progress tracked as "draining" / "trap due next cycle".
  bit          m_draining = 0;
  bit          m_trapping = 0;
  int          m_drain_len = 0;
  logic [31:0] m_vec = '0;
  logic [31:0] m_scyc = '0;
  logic [31:0] m_rcnt = '0;
  bit          last_ack = 0;

  function automatic exp_t model_step(input logic ifu, input logic ld, input logic ex,
                                      input logic lsu, input logic jmp, input logic [31:0] jaddr,
                                      input logic trap, input logic [31:0] tvec, input logic rstn);
    exp_t e;
    e.stall = 5'b0; e.flush = 5'b0; e.redir = 1'b0; e.addr = jaddr;
    e.ack = 1'b0; e.tmo = 1'b0; e.scyc = '0; e.rcnt = '0;
    if (!rstn) begin
      e.addr = RST_ADDR;
      m_draining = 0; m_trapping = 0; m_drain_len = 0; m_vec = '0;
      m_scyc = '0; m_rcnt = '0;
      return e;
    end
    if (m_trapping) begin
      e.flush = 5'b01110; e.redir = 1'b1; e.addr = m_vec; e.ack = 1'b1;
      m_trapping = 0;
    end else if (m_draining) begin
      m_drain_len++;
      e.stall = lsu ? 5'd31 : (ex ? 5'd7 : 5'd1);
      e.flush = (lsu || ex) ? 5'd0 : 5'd2;
      if (!(lsu || ex)) begin
        m_draining = 0; m_trapping = 1;
      end else if (m_drain_len == TMO) begin
        e.tmo = 1'b1; m_draining = 0; m_trapping = 1;
      end
    end else begin
      if (lsu) e.stall = 5'd31;
      else if (ex) begin e.stall = 5'd7; e.flush = 5'd8; end
      else if (trap) ;
      else if (jmp) begin e.flush = 5'd6; e.redir = 1'b1; end
      else if (ld) begin e.stall = 5'd3; e.flush = 5'd4; end
      else if (ifu) begin e.stall = 5'd1; e.flush = 5'd2; end
      if (trap) begin m_draining = 1; m_drain_len = 0; m_vec = tvec; end
    end
`ifdef PIPE_CTRL_PERF_EN
    e.scyc = m_scyc; e.rcnt = m_rcnt;
    m_scyc = m_scyc + 32'(e.stall[0]);
    m_rcnt = m_rcnt + 32'(e.redir);
`endif
    return e;
  endfunction

  task automatic applyStimulus(input logic ifu, input logic ld, input logic ex, input logic lsu,
                               input logic jmp, input logic [31:0] jaddr,
                               input logic trap, input logic [31:0] tvec, input logic rstn);
    exp_t e;
    @(posedge clk);
    #1;
    ifu_wait_i = ifu; ld_use_i = ld; ex_busy_i = ex; lsu_wait_i = lsu;
    jump_req_i = jmp; jump_addr_i = jaddr; trap_req_i = trap; trap_vec_i = tvec;
    rst_n = rstn;
    e = model_step(ifu, ld, ex, lsu, jmp, jaddr, trap, tvec, rstn);
    last_ack = e.ack;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput("stall_o", 32'(stall_o), 32'(e.stall));
      checkOutput("flush_o", 32'(flush_o), 32'(e.flush));
      checkOutput("redirect_o", 32'(redirect_o), 32'(e.redir));
      checkOutput("redirect_addr_o", redirect_addr_o, e.addr);
      checkOutput("trap_ack_o", 32'(trap_ack_o), 32'(e.ack));
      checkOutput("bus_timeout_o", 32'(bus_timeout_o), 32'(e.tmo));
      checkOutput("stall_cyc_o", stall_cyc_o, e.scyc);
      checkOutput("redirect_cnt_o", redirect_cnt_o, e.rcnt);
    end
  end

  initial begin
    bit          hold;
    logic [31:0] hvec;
    int          busy_pct;
    logic        r_lsu, r_ex, r_rst;
    hold = 0; hvec = '0; busy_pct = 25;
    $display("[TB] start");

    repeat (2) applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 32'h44, 0, 32'h0, 1);

    // ifu wait for three cycles
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 32'h10, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 0, 32'h10, 0, 32'h0, 1);
    // load-use and jump together: jump wins
    applyStimulus(0, 1, 0, 0, 1, 32'h80, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 0, 32'h80, 0, 32'h0, 1);
    // jump held behind a long EX op
    repeat (10) applyStimulus(0, 0, 1, 0, 1, 32'h200, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 1, 32'h200, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 0, 32'h200, 0, 32'h0, 1);
    // fast trap entry, requester holds until ack
    repeat (3) applyStimulus(0, 0, 0, 0, 1, 32'h300, 1, 32'h100, 1);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    // trap with data bus stuck: drain times out
    repeat (10) applyStimulus(0, 0, 0, 1, 0, 32'h0, 1, 32'h400, 1);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    // reset in the middle of a drain
    repeat (3) applyStimulus(0, 0, 0, 1, 0, 32'h0, 1, 32'h500, 1);
    repeat (2) applyStimulus(0, 0, 0, 1, 0, 32'h0, 1, 32'h500, 0);
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1);

    for (int i = 0; i < 2000; i++) begin
      if (i % 200 == 0) busy_pct = ($urandom % 2) ? 85 : 25;
      r_rst = (($urandom % 250) != 0);
      r_lsu = (($urandom % 100) < busy_pct / 3);
      r_ex  = (($urandom % 100) < (busy_pct * 2) / 3);
      if (!hold && (($urandom % 30) == 0)) begin
        hold = 1;
        hvec = $urandom;
      end
      applyStimulus(1'($urandom), 1'($urandom), r_ex, r_lsu, 1'($urandom),
                    $urandom, hold, hvec, r_rst);
      if (last_ack || !r_rst) hold = 0;
    end

    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
